flush_ctrl: RTL

- Parametrised control-hazard flush controller, the successor of the single-source jump flusher.
- Accepts three redirect sources: Jump, taken Branch and JumpReg. Each source has its own flush length.
- Drives one Flush line to the pipeline-register clear logic. Reports the active source and the remaining flush cycles to the hazard unit.
- Supports a pipeline Stall freeze and a selectable retrigger mode.

---
 rtl/flush_ctrl_if.sv | 27 ++
 rtl/flush_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/flush_ctrl_if.sv
// Purpose: redirect-event inputs and flush status outputs of flush_ctrl, bundled for the hazard unit.
// Latency: none, signal bundle only.
// Backpressure: none; i_stall is a freeze request, not a handshake.
// Ports (controller view): i_stall, i_jump, i_branch, i_jump_reg in; o_flush, o_flush_src, o_remaining out.
interface flush_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             i_stall;
  logic             i_jump;
  logic             i_branch;
  logic             i_jump_reg;
  logic             o_flush;
  logic [1:0]       o_flush_src;
  logic [CNT_W-1:0] o_remaining;

  // master: pipeline / hazard unit side that raises redirects and consumes flush status
  modport master (
    output i_stall, i_jump, i_branch, i_jump_reg,
    input  o_flush, o_flush_src, o_remaining
  );

  // slave: the flush controller itself
  modport slave (
    input  i_stall, i_jump, i_branch, i_jump_reg,
    output o_flush, o_flush_src, o_remaining
  );
endinterface

// File: rtl/flush_ctrl.sv
// Purpose: control-hazard flush controller for Jump, taken Branch and JumpReg redirects.
// Latency: flush starts the cycle after the redirect and lasts N stall-free cycles per source.
// Backpressure: i_stall freezes a running count; a load from idle always happens.
// Ports: i_clk, i_reset (sync, active-high); fc = flush_ctrl_if.slave carrying the
//        redirect/stall inputs and the o_flush / o_flush_src / o_remaining outputs.
`ifndef DEBUG_PRINT
`define DEBUG_PRINT 0
`endif

module flush_ctrl #(
  parameter int CNT_W       = 3,
  parameter int JUMP_N      = 3,
  parameter int BRANCH_N    = 3,
  parameter int JR_N        = 4,
  parameter int RETRIGGER   = 1,
  parameter int DEBUG_PRINT = `DEBUG_PRINT
) (
  input logic         i_clk,
  input logic         i_reset,
  flush_ctrl_if.slave fc
);

  localparam int MAX_JB = (JUMP_N > BRANCH_N) ? JUMP_N : BRANCH_N;
  localparam int MAX_N  = (MAX_JB > JR_N) ? MAX_JB : JR_N;

  // Counter must hold the longest flush without wrapping; debug flag is boolean.
  if ((((1 << CNT_W) - 1) < MAX_N) || (JUMP_N < 0) || (BRANCH_N < 0) || (JR_N < 0) ||
      (DEBUG_PRINT < 0) || (DEBUG_PRINT > 1)) begin : g_bad_params
    $error("flush_ctrl: CNT_W too small for flush lengths or bad DEBUG_PRINT");
  end

  localparam logic [CNT_W-1:0] LD_JUMP   = CNT_W'(JUMP_N);
  localparam logic [CNT_W-1:0] LD_BRANCH = CNT_W'(BRANCH_N);
  localparam logic [CNT_W-1:0] LD_JR     = CNT_W'(JR_N);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] SRC_NONE   = 2'b00;
  localparam logic [1:0] SRC_JUMP   = 2'b01;
  localparam logic [1:0] SRC_BRANCH = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_src;

  state_t           w_state;
  logic             w_evt;
  logic             w_load;
  logic [CNT_W-1:0] w_win_n;
  logic [1:0]       w_win_src;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_src_nxt;

  // State is implied by the counter; no separate state flop is needed.
  assign w_state = (r_cnt != '0) ? ST_FLUSH : ST_IDLE;
  assign w_evt   = fc.i_jump | fc.i_branch | fc.i_jump_reg;

  // Fixed priority JumpReg > Branch > Jump. The winner is used even when its
  // length is zero, so a lower-priority source never substitutes.
  always_comb begin
    w_win_n   = LD_JUMP;
    w_win_src = SRC_JUMP;
    if (fc.i_jump_reg) begin
      w_win_n   = LD_JR;
      w_win_src = SRC_JR;
    end else if (fc.i_branch) begin
      w_win_n   = LD_BRANCH;
      w_win_src = SRC_BRANCH;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_src_nxt = r_src;
    w_load    = 1'b0;
    case (w_state)
      // Stall does not block a load from idle: it only freezes a running count.
      ST_IDLE: w_load = w_evt;
      ST_FLUSH: begin
        if (w_evt && (RETRIGGER != 0)) begin
          // Retrigger discards the old count and overrides Stall this cycle.
          w_load = 1'b1;
        end else if (!fc.i_stall) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_src_nxt = SRC_NONE;
          end
        end
      end
      default: ;
    endcase
    if (w_load) begin
      w_cnt_nxt = w_win_n;
      // A zero-length source leaves the controller idle, so no source is reported.
      w_src_nxt = (w_win_n == '0) ? SRC_NONE : w_win_src;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_src <= SRC_NONE;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_src <= w_src_nxt;
    end
  end

  assign fc.o_flush     = (r_cnt != '0);
  assign fc.o_flush_src = r_src;
  assign fc.o_remaining = r_cnt;

endmodule
